// File: rtl/io_module_param.sv
// rtl/io_module_param.sv - Memory-mapped GPIO block with debounced inputs, edge interrupts and a temperature register
module io_module_param #(
   parameter int         NUM_IN          = 8,
   parameter logic [7:0] BASE_ADDR       = 8'hF0,
   parameter int         DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [7:0]        address,
   input  logic [7:0]        write_data,
   output logic [7:0]        read_data,
   input  logic [NUM_IN-1:0] in_pins,
   input  logic [7:0]        temp_data,
   output logic [7:0]        out_pins,
   output logic              irq
);

   localparam logic [2:0] OFF_IN_DATA   = 3'd0;
   localparam logic [2:0] OFF_OUT_DATA  = 3'd1;
   localparam logic [2:0] OFF_OUT_SET   = 3'd2;
   localparam logic [2:0] OFF_OUT_CLR   = 3'd3;
   localparam logic [2:0] OFF_OUT_TGL   = 3'd4;
   localparam logic [2:0] OFF_EDGE_STAT = 3'd5;
   localparam logic [2:0] OFF_IRQ_EN    = 3'd6;
   localparam logic [2:0] OFF_TEMP      = 3'd7;

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [NUM_IN-1:0] sync1;
   logic [NUM_IN-1:0] sync2;
   logic [NUM_IN-1:0] db;
   logic [NUM_IN-1:0] db_rise;
   logic [NUM_IN-1:0] edge_stat;
   logic [NUM_IN-1:0] irq_en;
   logic [NUM_IN-1:0] w1c_mask;
   logic [7:0]        out_data;
   logic [7:0]        temp_reg;
   logic [7:0]        in_ext;
   logic [7:0]        stat_ext;
   logic [7:0]        en_ext;
   logic [2:0]        offset;
   logic              in_window;
   logic              wr_hit;

   // Window is 8-aligned, so only the upper five address bits select it
   assign in_window = (address[7:3] == BASE_ADDR[7:3]);
   assign offset    = address[2:0];
   assign wr_hit    = mem_write && in_window;
   assign w1c_mask  = (wr_hit && offset == OFF_EDGE_STAT) ? write_data[NUM_IN-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_pins;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
      logic [15:0] cnt;
      logic        db_bit;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt    <= '0;
            db_bit <= 1'b0;
         end else if (sync2[i] == db_bit) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db_bit <= sync2[i];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end

      assign db[i]      = db_bit;
      assign db_rise[i] = sync2[i] && !db_bit && (cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         edge_stat <= '0;
         irq_en    <= '0;
         temp_reg  <= '0;
         irq       <= 1'b0;
      end else begin
         temp_reg <= temp_data;
         irq      <= |(edge_stat & irq_en);
         // A fresh rise is OR-ed in after the clear so it survives a same-edge W1C
         edge_stat <= (edge_stat & ~w1c_mask) | db_rise;
         if (wr_hit) begin
            case (offset)
               OFF_OUT_DATA: out_data <= write_data;
               OFF_OUT_SET:  out_data <= out_data | write_data;
               OFF_OUT_CLR:  out_data <= out_data & ~write_data;
               OFF_OUT_TGL:  out_data <= out_data ^ write_data;
               OFF_IRQ_EN:   irq_en   <= write_data[NUM_IN-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      in_ext                 = '0;
      in_ext[NUM_IN-1:0]     = db;
      stat_ext               = '0;
      stat_ext[NUM_IN-1:0]   = edge_stat;
      en_ext                 = '0;
      en_ext[NUM_IN-1:0]     = irq_en;
      read_data              = 8'h00;
      if (mem_read && in_window) begin
         case (offset)
            OFF_IN_DATA:   read_data = in_ext;
            OFF_OUT_DATA:  read_data = out_data;
            OFF_EDGE_STAT: read_data = stat_ext;
            OFF_IRQ_EN:    read_data = en_ext;
            OFF_TEMP:      read_data = temp_reg;
            default:       read_data = 8'h00;
         endcase
      end
   end

   assign out_pins = out_data;

endmodule

// File: tb/tb_io_module_param.sv
// tb/tb_io_module_param.sv - Scoreboard bench for io_module_param with a default and a narrow instance
module tb_io_module_param;

   localparam int         D1_IN   = 4;
   localparam logic [7:0] D1_BASE = 8'hE0;
   localparam int         D1_DB   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] address;
   logic [7:0] write_data;
   logic [7:0] in_pins;
   logic [7:0] temp_data;
   logic [7:0] read_data0, read_data1;
   logic [7:0] out_pins0, out_pins1;
   logic       irq0, irq1;

   always #5 clk = ~clk;

   io_module_param dut0 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .write_data(write_data), .read_data(read_data0),
      .in_pins(in_pins), .temp_data(temp_data), .out_pins(out_pins0), .irq(irq0)
   );

   io_module_param #(.NUM_IN(D1_IN), .BASE_ADDR(D1_BASE), .DEBOUNCE_CYCLES(D1_DB)) dut1 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .write_data(write_data), .read_data(read_data1),
      .in_pins(in_pins[D1_IN-1:0]), .temp_data(temp_data), .out_pins(out_pins1), .irq(irq1)
   );

   typedef struct {
      logic [7:0] rd0, rd1, out0, out1;
      logic       irq0, irq1;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   tests = 0;
   int   fails = 0;

   // Reference state: registers as the register map describes them, plus a pin-sample history
   logic [7:0] m_out [2];
   logic [7:0] m_est [2];
   logic [7:0] m_ien [2];
   logic [7:0] m_temp[2];
   logic [7:0] m_db  [2];
   logic       m_irq [2];
   logic [7:0] m_ph  [2][64];
   int         m_ecnt[2];

   function automatic int nin(int d);            return (d == 0) ? 8 : D1_IN; endfunction
   function automatic int dbc(int d);            return (d == 0) ? 16 : D1_DB; endfunction
   function automatic logic [7:0] base(int d);   return (d == 0) ? 8'hF0 : D1_BASE; endfunction
   function automatic logic [7:0] msk(int d);    return (d == 0) ? 8'hFF : 8'h0F; endfunction

   // Value seen by the debouncer at edge k: the pin as sampled two edges earlier, zero near reset
   function automatic logic [7:0] sval(int d, int k);
      if (k < 3) return 8'h00;
      return m_ph[d][(k - 2) % 64];
   endfunction

   function automatic logic [7:0] model_rd(int d, bit rd, logic [7:0] a);
      logic [7:0] bs;
      bs = base(d);
      if (!rd || a[7:3] != bs[7:3]) return 8'h00;
      case (a[2:0])
         3'd0: return m_db[d];
         3'd1: return m_out[d];
         3'd5: return m_est[d];
         3'd6: return m_ien[d];
         3'd7: return m_temp[d];
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step(int d, bit r, bit wr, logic [7:0] a, logic [7:0] wd,
                             logic [7:0] pins, logic [7:0] tmp);
      logic [7:0] rise, db_n, w1c, bs, sv;
      logic       irq_n;
      bit         flip;
      int         e;
      if (r) begin
         m_out[d] = 0; m_est[d] = 0; m_ien[d] = 0; m_temp[d] = 0;
         m_db[d] = 0; m_irq[d] = 0; m_ecnt[d] = 0;
         return;
      end
      irq_n = |(m_est[d] & m_ien[d]);
      e = m_ecnt[d] + 1;
      m_ph[d][e % 64] = pins & msk(d);
      rise = 0;
      db_n = m_db[d];
      // A level is accepted once it has differed from the accepted level for a full window
      for (int i = 0; i < nin(d); i++) begin
         flip = 1;
         for (int j = 0; j < dbc(d); j++) begin
            sv = sval(d, e - j);
            if (sv[i] == m_db[d][i]) flip = 0;
         end
         if (flip) begin
            db_n[i] = ~m_db[d][i];
            rise[i] = db_n[i];
         end
      end
      bs  = base(d);
      w1c = 0;
      if (wr && a[7:3] == bs[7:3]) begin
         case (a[2:0])
            3'd1: m_out[d] = wd;
            3'd2: m_out[d] = m_out[d] | wd;
            3'd3: m_out[d] = m_out[d] & ~wd;
            3'd4: m_out[d] = m_out[d] ^ wd;
            3'd5: w1c = wd;
            3'd6: m_ien[d] = wd & msk(d);
            default: ;
         endcase
      end
      m_est[d]  = ((m_est[d] & ~w1c) | rise) & msk(d);
      m_temp[d] = tmp;
      m_irq[d]  = irq_n;
      m_db[d]   = db_n;
      m_ecnt[d] = e;
   endtask

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check("read_data0", read_data0, cur.rd0);
         check("read_data1", read_data1, cur.rd1);
         check("out_pins0", out_pins0, cur.out0);
         check("out_pins1", out_pins1, cur.out1);
         check("irq0", {7'd0, irq0}, {7'd0, cur.irq0});
         check("irq1", {7'd0, irq1}, {7'd0, cur.irq1});
      end
   end

   task automatic cyc(bit t_rst, bit t_rd, bit t_wr, logic [7:0] t_a, logic [7:0] t_wd,
                      logic [7:0] t_pins, logic [7:0] t_tmp, bit t_chk);
      exp_t e;
      rst = t_rst; mem_read = t_rd; mem_write = t_wr; address = t_a;
      write_data = t_wd; in_pins = t_pins; temp_data = t_tmp;
      if (t_chk) begin
         e.rd0  = model_rd(0, t_rd, t_a);
         e.rd1  = model_rd(1, t_rd, t_a);
         e.out0 = m_out[0];
         e.out1 = m_out[1];
         e.irq0 = m_irq[0];
         e.irq1 = m_irq[1];
         exp_q.push_back(e);
      end
      @(posedge clk);
      model_step(0, t_rst, t_wr, t_a, t_wd, t_pins, t_tmp);
      model_step(1, t_rst, t_wr, t_a, t_wd, t_pins, t_tmp);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pins;
      logic [7:0] a;
      bit         r, rd, wr;
      pins = 8'h00;

      cyc(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      cyc(1, 1, 0, 8'hF1, 8'h00, 8'hFF, 8'h77, 1);
      cyc(1, 1, 1, 8'hE6, 8'hFF, 8'hFF, 8'h77, 1);

      cyc(0, 0, 1, 8'hF1, 8'hA5, pins, 8'h00, 1);
      cyc(0, 0, 1, 8'hF2, 8'h0F, pins, 8'h00, 1);
      cyc(0, 0, 1, 8'hF3, 8'hA0, pins, 8'h00, 1);
      cyc(0, 0, 1, 8'hF4, 8'hFF, pins, 8'h00, 1);
      cyc(0, 1, 0, 8'hF1, 8'h00, pins, 8'h00, 1);

      cyc(0, 0, 1, 8'hE6, 8'hFF, pins, 8'h00, 1);
      cyc(0, 1, 0, 8'hE6, 8'h00, pins, 8'h00, 1);
      cyc(0, 1, 0, 8'hF0, 8'h00, pins, 8'h3C, 1);
      cyc(0, 1, 0, 8'hE7, 8'h00, pins, 8'h3C, 1);
      cyc(0, 1, 1, 8'hF0, 8'h00, pins, 8'h3C, 1);

      cyc(0, 0, 1, 8'hF6, 8'h08, pins, 8'h00, 1);
      pins = 8'h08;
      for (int k = 0; k < 24; k++) cyc(0, 1, 0, (k % 2) ? 8'hF5 : 8'hF0, 8'h00, pins, 8'h00, 1);
      cyc(0, 1, 1, 8'hF5, 8'h08, pins, 8'h00, 1);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 8'hF5, 8'h00, pins, 8'h00, 1);

      pins = 8'h00;
      for (int k = 0; k < 20; k++) cyc(0, 1, 0, 8'hF0, 8'h00, pins, 8'h00, 1);
      pins = 8'h20;
      for (int k = 0; k < 15; k++) cyc(0, 1, 0, 8'hF0, 8'h00, pins, 8'h00, 1);
      pins = 8'h00;
      for (int k = 0; k < 20; k++) cyc(0, 1, 0, (k % 2) ? 8'hF5 : 8'hF0, 8'h00, pins, 8'h00, 1);

      // Bit 3 rises; the W1C lands on the edge where the debounced level flips
      pins = 8'h08;
      for (int k = 1; k <= 20; k++) cyc(0, 1, (k == 18), 8'hF5, 8'h08, pins, 8'h00, 1);
      cyc(0, 1, 0, 8'hF5, 8'h00, pins, 8'h00, 1);

      pins = 8'h00;
      cyc(0, 0, 1, 8'hF1, 8'h55, pins, 8'h00, 1);
      for (int k = 0; k < 20; k++) cyc(0, 1, 0, 8'hF0, 8'h00, pins, 8'h00, 1);
      pins = 8'h0F;
      for (int k = 0; k < 8; k++) cyc(0, 1, 0, 8'hF0, 8'h00, pins, 8'h00, 1);
      cyc(1, 1, 0, 8'hF1, 8'h00, pins, 8'h00, 1);
      for (int k = 0; k < 22; k++) cyc(0, 1, 0, (k % 2) ? 8'hF5 : 8'hF0, 8'h00, pins, 8'h00, 1);

      for (int k = 0; k < 800; k++) begin
         r  = ($urandom_range(0, 199) == 0);
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0, 1:    a = {5'h1E, 3'($urandom_range(0, 7))};
            2:       a = {5'h1C, 3'($urandom_range(0, 7))};
            default: a = 8'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) pins[$urandom_range(0, 7)] ^= 1'b1;
         cyc(r, rd, wr, a, 8'($urandom), pins, 8'($urandom), 1);
      end

      mem_read = 1'b0; mem_write = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/io_module_param.md
IO_MODULE_PARAM -- requirements
Module: io_module_param

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 8: number of input channels, legal range 1..8.
REQ-002 The block SHALL have parameter BASE_ADDR, default 8'hF0: base of an 8-byte register window at BASE_ADDR..BASE_ADDR+7, aligned to 8.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept an input change, legal range 2..65535.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port mem_read, input, 1 bit: read strobe.
REQ-007 The block SHALL have port mem_write, input, 1 bit: write strobe.
REQ-008 The block SHALL have port address, input, 8 bits: register address.
REQ-009 The block SHALL have port write_data, input, 8 bits: write data.
REQ-010 The block SHALL have port read_data, output, 8 bits: read data.
REQ-011 The block SHALL have port in_pins, input, NUM_IN bits: asynchronous raw inputs.
REQ-012 The block SHALL have port temp_data, input, 8 bits: sensor value.
REQ-013 The block SHALL have port out_pins, output, 8 bits: output register drive.
REQ-014 The block SHALL have port irq, output, 1 bit: registered interrupt request.

Function
REQ-015 Register map (offset from BASE_ADDR) SHALL be:
- 0 IN_DATA: RO, debounced inputs, upper 8-NUM_IN bits read 0.
- 1 OUT_DATA: RW.
- 2 OUT_SET: WO, OUT_DATA |= wd.
- 3 OUT_CLR: WO, OUT_DATA &= ~wd.
- 4 OUT_TGL: WO, OUT_DATA ^= wd.
- 5 EDGE_STAT: R/W1C.
- 6 IRQ_EN: RW, upper 8-NUM_IN bits read 0 and ignore writes.
- 7 TEMP: RO.
REQ-016 WO offsets 2-4 SHALL read 8'h00.
REQ-017 read_data SHALL be combinational: 8'h00 when mem_read=0 or address is outside the window, otherwise the addressed register's current (pre-edge) value.
REQ-018 Writes SHALL take effect at the clk edge on which mem_write=1; writes outside the window and writes to RO offsets SHALL be ignored.
REQ-019 A simultaneous read and write to the same register SHALL return the old value.
REQ-020 Each in_pins bit SHALL pass through a 2-flop synchroniser; the second stage is sync[i].
REQ-021 Each channel SHALL have a debounce counter:
- counter clears on every cycle where sync[i]==db[i];
- otherwise it increments;
- db[i] takes sync[i] on the edge where the counter equals DEBOUNCE_CYCLES-1, and the counter clears on that same edge.
REQ-022 A pin held at a new level SHALL appear in IN_DATA exactly DEBOUNCE_CYCLES+2 edges after it is first sampled.
REQ-023 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change db.
REQ-024 EDGE_STAT[i] SHALL set on the edge where db[i] goes 0->1.
REQ-025 EDGE_STAT[i] SHALL clear on a write with write_data[i]=1 to offset 5.
REQ-026 When a set and a W1C of EDGE_STAT[i] occur on the same edge, the set SHALL win.
REQ-027 irq SHALL be the registered value of OR(EDGE_STAT & IRQ_EN), i.e. one edge after the contributing status bit or enable bit becomes set.
REQ-028 TEMP SHALL be temp_data registered every cycle, one-edge latency.
REQ-029 out_pins SHALL equal OUT_DATA with no combinational path from write_data.

Reset
REQ-030 While rst=1 at a clk edge, every register SHALL be cleared: synchronisers, db, counters, OUT_DATA, EDGE_STAT, IRQ_EN, TEMP, irq.
REQ-031 Consequently out_pins=8'h00 and irq=0 from the first edge with rst=1.
REQ-032 A reset asserted mid-debounce SHALL discard the partial count.
REQ-033 After rst is released, no EDGE_STAT bit SHALL set unless a pin is held high for DEBOUNCE_CYCLES+2 edges after release.
REQ-034 read_data SHALL remain combinational during reset and reflect the cleared values.

Verification
REQ-035 Write 8'hA5 to 8'hF1, then 8'h0F to 8'hF2, 8'hA0 to 8'hF3, 8'hFF to 8'hF4 -> out_pins = A5, AF, 0F, F0 on successive edges; a read of 8'hF1 returns F0.
REQ-036 With DEBOUNCE_CYCLES=16, in_pins[3] goes 0->1 and is held -> IN_DATA bit 3 = 1 exactly 18 edges later; a 15-cycle high pulse leaves IN_DATA = 0.
REQ-037 With IRQ_EN=8'h08, debounced rise on bit 3 -> EDGE_STAT=8'h08 and irq=1 one edge later; write 8'h08 to 8'hF5 -> EDGE_STAT=0 and irq=0 one edge later.
REQ-038 A W1C of bit 3 on the same edge as a new bit-3 rise -> EDGE_STAT bit 3 remains 1.
REQ-039 With NUM_IN=4 and BASE_ADDR=8'hE0, write 8'hFF to 8'hE6 -> a read of 8'hE6 returns 8'h0F; reads of 8'hF0 return 8'h00; temp_data=8'h3C -> a read of 8'hE7 returns 3C one edge later.
REQ-040 Assert rst mid-debounce with OUT_DATA=8'h55 -> out_pins=0, irq=0, IN_DATA=0 on that edge; a full DEBOUNCE_CYCLES+2 hold is required after release.
